// File: rtl/riscv_mem_pkg.sv
// Shared types and default widths for the unified instruction/data memory
// port arbiter.
package riscv_mem_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // Arbiter FSM encoding
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_D = 2'd1,
        BUSY_I = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch stage, the memory stage, the single memory
// port and the hazard unit stall inputs.
//
// Handshake semantics (all three channels):
//   - A requester raises req with its fields and holds them stable until it
//     sees ack; ack is a one-cycle pulse and rdata is valid only with it.
//     In the cycle after ack the requester drops req or presents a new access.
//   - On the memory side mem_req and all mem_* fields are held stable until
//     mem_ready=1; mem_ready is ignored while mem_req=0.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_port_arbiter_if
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    // fetch side
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    // data side
    logic                dm_req;
    logic                dm_we;
    logic [ADDR_W-1:0]   dm_addr;
    logic [DATA_W-1:0]   dm_wdata;
    logic [DATA_W/8-1:0] dm_be;
    logic [DATA_W-1:0]   dm_rdata;
    logic                dm_ack;
    // memory side
    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_be;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_ready;
    // to hazard_unit
    logic stall_if;
    logic stall_mem;

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_ack,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        output dm_rdata, dm_ack,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_ready,
        output stall_if, stall_mem
    );

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_ack,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
        input  dm_rdata, dm_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ready,
        input  stall_if, stall_mem
    );

endinterface

// File: rtl/arb_perf_counter.sv
// Enable-gated 32-bit event counter that wraps at 2^32.
module arb_perf_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [31:0] count
);

    // Count one per enabled cycle, natural wrap on overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported unified memory between IF and MEM.
// Data accesses win over fetches; one access is outstanding at a time.
// Optional feature: define MEM_ARB_PERF_EN to add the perf_conflict and
// perf_wait counters.
module mem_port_arbiter
    import riscv_mem_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    mem_port_arbiter_if.slave    bus,
    output arb_state_t           dbg_state
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]          perf_conflict,
    output logic [31:0]          perf_wait
`endif
);

    arb_state_t state;
    arb_state_t next_state;
    logic       grant_d;
    logic       grant_i;
    logic       done;

    // A requester whose ack is high this cycle is still holding the old
    // access, so it is masked from arbitration until the following cycle.
    always_comb begin
        next_state = state;
        grant_d    = 1'b0;
        grant_i    = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.dm_req && !bus.dm_ack) begin
                    grant_d    = 1'b1;
                    next_state = BUSY_D;
                end else if (bus.if_req && !bus.if_ack) begin
                    grant_i    = 1'b1;
                    next_state = BUSY_I;
                end
            end
            BUSY_D, BUSY_I: begin
                if (bus.mem_ready) begin
                    done       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Memory-side request: latched on the grant edge, held until mem_ready
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_be    <= '0;
        end else if (grant_d) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.dm_we;
            bus.mem_addr  <= bus.dm_addr;
            bus.mem_wdata <= bus.dm_wdata;
            bus.mem_be    <= bus.dm_be;
        end else if (grant_i) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= bus.if_addr;
            bus.mem_wdata <= '0;
            bus.mem_be    <= '0;
        end else if (done) begin
            bus.mem_req   <= 1'b0;
        end
    end

    // Completion: one-cycle ack pulse; loads and fetches capture read data,
    // stores leave dm_rdata untouched
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.if_ack   <= 1'b0;
            bus.dm_ack   <= 1'b0;
            bus.if_rdata <= '0;
            bus.dm_rdata <= '0;
        end else begin
            bus.if_ack <= 1'b0;
            bus.dm_ack <= 1'b0;
            if (done && state == BUSY_D) begin
                bus.dm_ack <= 1'b1;
                if (!bus.mem_we) begin
                    bus.dm_rdata <= bus.mem_rdata;
                end
            end
            if (done && state == BUSY_I) begin
                bus.if_ack   <= 1'b1;
                bus.if_rdata <= bus.mem_rdata;
            end
        end
    end

    // Stalls release in the ack cycle so the pipeline advances on that edge
    assign bus.stall_if  = bus.if_req & ~bus.if_ack;
    assign bus.stall_mem = bus.dm_req & ~bus.dm_ack;
    assign dbg_state     = state;

`ifdef MEM_ARB_PERF_EN
    logic conflict_en;
    logic wait_en;

    // A waiting fetch counts as a conflict while the port is busy or the
    // data side still holds its request
    assign conflict_en = bus.stall_if & ((state != IDLE) | bus.dm_req);
    assign wait_en     = (state != IDLE) & ~bus.mem_ready;

    arb_perf_counter u_conflict_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (conflict_en),
        .count (perf_conflict)
    );

    arb_perf_counter u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (wait_en),
        .count (perf_wait)
    );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;
    import riscv_mem_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;
    arb_state_t dbg_state;
    int n_cmp;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_conflict;
    logic [31:0] perf_wait;
`endif

    mem_port_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_conflict (perf_conflict),
        .perf_wait     (perf_wait)
`endif
    );

    // ---------------- driver tasks ----------------
    // Inputs change 1 ns after the rising edge; checks run 1 ns later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.dm_req    = 1'b0;
        bus.dm_we     = 1'b0;
        bus.dm_addr   = '0;
        bus.dm_wdata  = '0;
        bus.dm_be     = '0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        #1;
        n_cmp++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        n_cmp++; if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0) begin n_err++; $display("FAIL reset_mem_req_we: got %b%b want 00", bus.mem_req, bus.mem_we); end
        n_cmp++; if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0 || bus.mem_be !== 4'h0) begin n_err++; $display("FAIL reset_mem_fields: got %h %h %h want 0", bus.mem_addr, bus.mem_wdata, bus.mem_be); end
        n_cmp++; if (bus.if_ack !== 1'b0 || bus.dm_ack !== 1'b0 || bus.if_rdata !== 32'h0 || bus.dm_rdata !== 32'h0) begin n_err++; $display("FAIL reset_acks_rdata: got %b %b %h %h want 0", bus.if_ack, bus.dm_ack, bus.if_rdata, bus.dm_rdata); end
    endtask

    task automatic test_fetch_only();
        apply_reset();
        // cycle 0
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        #1;
        n_cmp++; if (bus.stall_if !== 1'b1) begin n_err++; $display("FAIL fetch_stall_c0: got %b want 1", bus.stall_if); end
        next_cycle(); // cycle 1
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h00500093;
        #1;
        n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100 || bus.mem_we !== 1'b0 || bus.mem_be !== 4'h0) begin n_err++; $display("FAIL fetch_mem_fields: got req=%b addr=%h we=%b be=%h want 1 100 0 0", bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_be); end
        n_cmp++; if (dbg_state !== BUSY_I) begin n_err++; $display("FAIL fetch_state_busy: got %0d want 2", dbg_state); end
        next_cycle(); // cycle 2
        bus.mem_ready = 1'b0;
        #1;
        n_cmp++; if (bus.if_ack !== 1'b1 || bus.if_rdata !== 32'h00500093) begin n_err++; $display("FAIL fetch_ack_rdata: got %b %h want 1 00500093", bus.if_ack, bus.if_rdata); end
        n_cmp++; if (bus.stall_if !== 1'b0) begin n_err++; $display("FAIL fetch_stall_c2: got %b want 0", bus.stall_if); end
        next_cycle(); // cycle 3: requester drops, masked request not re-granted
        bus.if_req = 1'b0;
        #1;
        n_cmp++; if (bus.if_ack !== 1'b0 || bus.mem_req !== 1'b0 || dbg_state !== IDLE) begin n_err++; $display("FAIL fetch_masked: got ack=%b req=%b st=%0d want 0 0 0", bus.if_ack, bus.mem_req, dbg_state); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h104;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hAAAA0001;
        next_cycle(); // 1
        next_cycle(); // 2: ack
        #1;
        n_cmp++; if (bus.if_ack !== 1'b1 || bus.if_rdata !== 32'hAAAA0001) begin n_err++; $display("FAIL b2b_first_ack: got %b %h want 1 aaaa0001", bus.if_ack, bus.if_rdata); end
        next_cycle(); // 3: new access presented
        bus.if_addr   = 32'h108;
        bus.mem_rdata = 32'hAAAA0002;
        next_cycle(); // 4
        #1;
        n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h108 || bus.if_ack !== 1'b0) begin n_err++; $display("FAIL b2b_second_req: got req=%b addr=%h ack=%b want 1 108 0", bus.mem_req, bus.mem_addr, bus.if_ack); end
        next_cycle(); // 5
        #1;
        n_cmp++; if (bus.if_ack !== 1'b1 || bus.if_rdata !== 32'hAAAA0002) begin n_err++; $display("FAIL b2b_second_ack: got %b %h want 1 aaaa0002", bus.if_ack, bus.if_rdata); end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_conflict();
        apply_reset();
        // cycle 0: both request, memory always ready
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h104;
        bus.dm_req    = 1'b1;
        bus.dm_we     = 1'b0;
        bus.dm_addr   = 32'h2000;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h11111111;
        #1;
        n_cmp++; if (bus.stall_if !== 1'b1 || bus.stall_mem !== 1'b1) begin n_err++; $display("FAIL conf_stall_c0: got %b%b want 11", bus.stall_if, bus.stall_mem); end
        next_cycle(); // 1
        #1;
        n_cmp++; if (dbg_state !== BUSY_D || bus.mem_addr !== 32'h2000 || bus.mem_req !== 1'b1) begin n_err++; $display("FAIL conf_data_first: got st=%0d addr=%h req=%b want 1 2000 1", dbg_state, bus.mem_addr, bus.mem_req); end
        n_cmp++; if (bus.stall_if !== 1'b1) begin n_err++; $display("FAIL conf_stall_c1: got %b want 1", bus.stall_if); end
        next_cycle(); // 2
        bus.mem_rdata = 32'h22222222;
        #1;
        n_cmp++; if (bus.dm_ack !== 1'b1 || bus.dm_rdata !== 32'h11111111 || bus.stall_mem !== 1'b0) begin n_err++; $display("FAIL conf_dm_ack: got %b %h stall=%b want 1 11111111 0", bus.dm_ack, bus.dm_rdata, bus.stall_mem); end
        n_cmp++; if (bus.stall_if !== 1'b1 || bus.mem_req !== 1'b0) begin n_err++; $display("FAIL conf_c2: got stall_if=%b req=%b want 1 0", bus.stall_if, bus.mem_req); end
        next_cycle(); // 3
        bus.dm_req = 1'b0;
        #1;
        n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h104 || bus.dm_ack !== 1'b0 || bus.stall_if !== 1'b1) begin n_err++; $display("FAIL conf_fetch_req: got req=%b addr=%h dm_ack=%b stall=%b want 1 104 0 1", bus.mem_req, bus.mem_addr, bus.dm_ack, bus.stall_if); end
        next_cycle(); // 4
        #1;
        n_cmp++; if (bus.if_ack !== 1'b1 || bus.if_rdata !== 32'h22222222 || bus.stall_if !== 1'b0) begin n_err++; $display("FAIL conf_if_ack: got %b %h stall=%b want 1 22222222 0", bus.if_ack, bus.if_rdata, bus.stall_if); end
`ifdef MEM_ARB_PERF_EN
        n_cmp++; if (perf_conflict !== 32'd4 || perf_wait !== 32'd0) begin n_err++; $display("FAIL perf_conflict: got %0d wait=%0d want 4 0", perf_conflict, perf_wait); end
`endif
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_store_wait();
        apply_reset();
        // load first so dm_rdata holds a known non-zero value
        bus.dm_req    = 1'b1;
        bus.dm_we     = 1'b0;
        bus.dm_addr   = 32'h3000;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hCAFEF00D;
        next_cycle(); // 1
        next_cycle(); // 2: load ack
        #1;
        n_cmp++; if (bus.dm_ack !== 1'b1 || bus.dm_rdata !== 32'hCAFEF00D) begin n_err++; $display("FAIL store_preload: got %b %h want 1 cafef00d", bus.dm_ack, bus.dm_rdata); end
        next_cycle(); // 3: store presented, three wait states follow
        bus.dm_we     = 1'b1;
        bus.dm_addr   = 32'h3004;
        bus.dm_wdata  = 32'hDEADBEEF;
        bus.dm_be     = 4'b0011;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h55555555;
        for (int c = 4; c <= 7; c++) begin
            next_cycle();
            if (c == 7) bus.mem_ready = 1'b1;
            #1;
            n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h3004 || bus.mem_wdata !== 32'hDEADBEEF || bus.mem_be !== 4'b0011 || bus.dm_ack !== 1'b0) begin n_err++; $display("FAIL store_hold_c%0d: got req=%b we=%b addr=%h wd=%h be=%b ack=%b want 1 1 3004 deadbeef 0011 0", c, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be, bus.dm_ack); end
        end
        next_cycle(); // 8
        bus.mem_ready = 1'b0;
        #1;
        n_cmp++; if (bus.dm_ack !== 1'b1 || bus.dm_rdata !== 32'hCAFEF00D || bus.mem_req !== 1'b0) begin n_err++; $display("FAIL store_ack: got %b rdata=%h req=%b want 1 cafef00d 0", bus.dm_ack, bus.dm_rdata, bus.mem_req); end
        next_cycle(); // 9
        bus.dm_req = 1'b0;
        #1;
        n_cmp++; if (bus.dm_ack !== 1'b0) begin n_err++; $display("FAIL store_ack_pulse: got %b want 0", bus.dm_ack); end
`ifdef MEM_ARB_PERF_EN
        n_cmp++; if (perf_wait !== 32'd3) begin n_err++; $display("FAIL perf_wait: got %0d want 3", perf_wait); end
`endif
        clear_inputs();
    endtask

    task automatic test_reset_busy();
        apply_reset();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h200;
        next_cycle(); // 1
        next_cycle(); // 2
        #1;
        n_cmp++; if (dbg_state !== BUSY_I || bus.mem_req !== 1'b1) begin n_err++; $display("FAIL rstbusy_pre: got st=%0d req=%b want 2 1", dbg_state, bus.mem_req); end
        reset       = 1'b1;
        bus.if_req  = 1'b0;
        next_cycle(); // 3
        reset = 1'b0;
        #1;
        n_cmp++; if (dbg_state !== IDLE || bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0 || bus.if_ack !== 1'b0 || bus.if_rdata !== 32'h0) begin n_err++; $display("FAIL rstbusy_post: got st=%0d req=%b addr=%h ack=%b rd=%h want 0 0 0 0 0", dbg_state, bus.mem_req, bus.mem_addr, bus.if_ack, bus.if_rdata); end
        next_cycle(); // 4
        #1;
        n_cmp++; if (bus.if_ack !== 1'b0 || bus.dm_ack !== 1'b0) begin n_err++; $display("FAIL rstbusy_no_ack: got %b %b want 0 0", bus.if_ack, bus.dm_ack); end
    endtask

    task automatic test_ready_idle();
        apply_reset();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h77777777;
        next_cycle();
        next_cycle();
        #1;
        n_cmp++; if (dbg_state !== IDLE || bus.if_ack !== 1'b0 || bus.dm_ack !== 1'b0 || bus.mem_req !== 1'b0) begin n_err++; $display("FAIL ready_idle: got st=%0d ack=%b%b req=%b want 0 00 0", dbg_state, bus.if_ack, bus.dm_ack, bus.mem_req); end
        n_cmp++; if (bus.if_rdata !== 32'h0 || bus.dm_rdata !== 32'h0) begin n_err++; $display("FAIL ready_idle_rdata: got %h %h want 0 0", bus.if_rdata, bus.dm_rdata); end
        clear_inputs();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_fetch_only();
        test_back_to_back();
        test_conflict();
        test_store_wait();
        test_reset_busy();
        test_ready_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
